// File: rtl/load_store_unit.sv
// Load/store unit: one memory transaction in flight between the controller and the data bus.
// Optional MISALIGN_TRAP_EN: abort misaligned halfword/word accesses without touching the bus.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_valid,
  output logic        core_req_ack,
  input  logic [31:0] core_addr,
  input  logic [7:0]  core_type,
  input  logic [31:0] core_wdata,
  output logic        core_done,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic [31:0] Address,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Write_data,
  output logic [3:0]  Write_strb,
  input  logic        Mem_Req_Ack,
  input  logic [31:0] Read_data,
  input  logic        Read_data_Valid,
  output logic        Read_data_Ack
);

  localparam int T_LW  = 0;
  localparam int T_LB  = 1;
  localparam int T_LBU = 2;
  localparam int T_LH  = 3;
  localparam int T_LHU = 4;
  localparam int T_SW  = 5;
  localparam int T_SB  = 6;
  localparam int T_SH  = 7;

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       addr_q;
  logic [7:0]        type_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [31:0]       rdata_q;

  logic accept;
  logic capture;
  logic misalign;
  logic is_load_q;
  logic tmo_hit;

  function automatic logic is_onehot(input logic [7:0] t);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (t[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return seen && !multi;
  endfunction

  function automatic logic [3:0] store_strb(input logic [7:0] t, input logic [1:0] o);
    logic [3:0] s;
    s = 4'b0000;
    if (t[T_SW])      s = 4'b1111;
    else if (t[T_SH]) s = o[1] ? 4'b1100 : 4'b0011;
    else if (t[T_SB]) s = 4'b0001 << o;
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [7:0] t, input logic [31:0] w);
    logic [31:0] d;
    d = w;
    if (t[T_SH])      d = {2{w[15:0]}};
    else if (t[T_SB]) d = {4{w[7:0]}};
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [7:0] t, input logic [1:0] o,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (o)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = o[1] ? rd[31:16] : rd[15:0];
    r = rd;
    if (t[T_LB])       r = {{24{b[7]}}, b};
    else if (t[T_LBU]) r = {24'd0, b};
    else if (t[T_LH])  r = {{16{h[15]}}, h};
    else if (t[T_LHU]) r = {16'd0, h};
    return r;
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((core_type[T_LW] | core_type[T_SW]) & (core_addr[1:0] != 2'b00)) |
                    ((core_type[T_LH] | core_type[T_LHU] | core_type[T_SH]) & core_addr[0]);
`else
  assign misalign = 1'b0;
`endif

  assign is_load_q = |type_q[T_LHU:T_LW];
  assign tmo_hit   = TMO_EN && (cnt_q == TMO_LAST);
  assign accept    = (state_q == S_IDLE) && core_req_valid;
  assign capture   = (state_q == S_RESP) && Read_data_Valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Request fields are frozen at acceptance so the bus sees stable values for the whole REQ phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      type_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= core_addr;
        type_q  <= core_type;
        wdata_q <= store_data(core_type, core_wdata);
        strb_q  <= store_strb(core_type, core_addr[1:0]);
      end
      if (capture) begin
        rdata_q <= load_extract(type_q, addr_q[1:0], Read_data);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (core_req_valid) begin
          cnt_d = '0;
          if (!is_onehot(core_type) || misalign) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
            err_d   = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (Mem_Req_Ack) begin
          cnt_d   = '0;
          state_d = is_load_q ? S_RESP : S_DONE;
        end else if (tmo_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (Read_data_Valid) begin
          state_d = S_DONE;
        end else if (tmo_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    core_req_ack  = accept;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    Read_data_Ack = 1'b0;
    core_done     = 1'b0;
    core_err      = 1'b0;
    case (state_q)
      S_REQ: begin
        MemRead  = is_load_q;
        MemWrite = !is_load_q;
      end
      S_RESP: Read_data_Ack = 1'b1;
      S_DONE: begin
        core_done = 1'b1;
        core_err  = err_q;
      end
      default: ;
    endcase
  end

  assign Address    = {addr_q[31:2], 2'b00};
  assign Write_data = wdata_q;
  assign Write_strb = strb_q;
  assign core_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized transactions against a plain-arithmetic model.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid;
  logic        core_req_ack;
  logic [31:0] core_addr;
  logic [7:0]  core_type;
  logic [31:0] core_wdata;
  logic        core_done;
  logic [31:0] core_rdata;
  logic        core_err;
  logic [31:0] Address;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ack;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ack;

  load_store_unit #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ack(core_req_ack),
    .core_addr(core_addr), .core_type(core_type), .core_wdata(core_wdata),
    .core_done(core_done), .core_rdata(core_rdata), .core_err(core_err),
    .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
    .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ack(Mem_Req_Ack),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ack(Read_data_Ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          bus;
    int          acc_cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] cur_rword = '0;
  int          cur_req_d = 0;
  int          cur_resp_d = 0;
  bit          cur_noack = 1'b0;
  bit          cur_nvalid = 1'b0;
  logic [31:0] cur_exp_addr = '0;
  logic [3:0]  cur_exp_strb = '0;
  logic [31:0] cur_exp_wdata = '0;
  int          bus_seen = 0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext_load(input logic [7:0] t, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (t)
      8'h02:   return b[7]  ? (b | 32'hFFFF_FF00) : b;
      8'h04:   return b;
      8'h08:   return h[15] ? (h | 32'hFFFF_0000) : h;
      8'h10:   return h;
      default: return w;
    endcase
  endfunction

  // Bus responder: acks after cur_req_d wait cycles, returns data after cur_resp_d, else noise.
  int req_wait = 0;
  int resp_wait = 0;
  initial begin
    Mem_Req_Ack = 1'b0;
    Read_data_Valid = 1'b0;
    Read_data = '0;
    forever begin
      @(negedge clk);
      Mem_Req_Ack = 1'b0;
      Read_data_Valid = 1'b0;
      Read_data = $urandom;
      if (!rst && (MemRead || MemWrite)) begin
        if (req_wait == 0) begin
          bus_seen = MemRead ? 1 : 2;
          chk("bus_addr", Address, cur_exp_addr);
          chk("bus_strb", 32'(Write_strb), 32'(cur_exp_strb));
          if (MemWrite) chk("bus_wdata", Write_data, cur_exp_wdata);
        end
        if (!cur_noack && req_wait >= cur_req_d) Mem_Req_Ack = 1'b1;
        req_wait++;
      end else begin
        req_wait = 0;
        Mem_Req_Ack = ($urandom_range(0, 3) == 0);
      end
      if (!rst && Read_data_Ack) begin
        if (!cur_nvalid && resp_wait >= cur_resp_d) begin
          Read_data_Valid = 1'b1;
          Read_data = cur_rword;
        end
        resp_wait++;
      end else begin
        resp_wait = 0;
        Read_data_Valid = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: every core_done is checked against the oldest scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && core_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(core_done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("core_rdata", core_rdata, e.rdata);
          chk("core_err", 32'(core_err), 32'(e.err));
          chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
          chk("bus_kind", 32'(bus_seen), 32'(e.bus));
          chk("ack_in_done", 32'(core_req_ack), 32'd0);
          chk("bus_idle_in_done", 32'({MemRead, MemWrite, Read_data_Ack}), 32'd0);
        end
        bus_seen = 0;
      end
    end
  end

  task automatic set_bus_expect(input logic [31:0] a, input logic [7:0] t, input logic [31:0] wd);
    cur_exp_addr = a & ~32'h3;
    cur_exp_strb = 4'b0000;
    cur_exp_wdata = wd;
    if (t == 8'h20) cur_exp_strb = 4'b1111;
    else if (t == 8'h80) begin
      cur_exp_strb = a[1] ? 4'b1100 : 4'b0011;
      cur_exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
    end else if (t == 8'h40) begin
      cur_exp_strb = 4'b0001 << a[1:0];
      cur_exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
    end
  endtask

  task automatic wait_ack(output bit ok);
    int waited = 0;
    #1;
    while (!core_req_ack && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    ok = core_req_ack;
    chk("req_ack", 32'(core_req_ack), 32'd1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [7:0] t, input logic [31:0] wd,
                       input logic [31:0] rw, input int rqd, input int rsd,
                       input bit noack, input bit nvalid);
    exp_t e;
    bit legal, mis, ld, ok;
    int waited;
    legal = ($countones(t) == 1);
    ld = legal && (t[4:0] != 5'd0);
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = legal && ((((t == 8'h01) || (t == 8'h20)) && (a[1:0] != 2'b00)) ||
                    (((t == 8'h08) || (t == 8'h10) || (t == 8'h80)) && a[0]));
`endif
    cur_rword = rw; cur_req_d = rqd; cur_resp_d = rsd;
    cur_noack = noack; cur_nvalid = nvalid;
    set_bus_expect(a, t, wd);
    e.rdata = last_rdata;
    e.err = 1'b0;
    e.bus = 0;
    if (!legal || mis) begin
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      e.bus = ld ? 1 : 2;
      if (noack) begin
        e.err = 1'b1;
        e.lat = 1 + TMO;
      end else if (!ld) begin
        e.lat = 2 + rqd;
      end else if (nvalid) begin
        e.err = 1'b1;
        e.lat = 2 + rqd + TMO;
      end else begin
        e.lat = 3 + rqd + rsd;
        e.rdata = ext_load(t, a, rw);
      end
    end
    core_addr = a; core_type = t; core_wdata = wd; core_req_valid = 1'b1;
    wait_ack(ok);
    if (ok) begin
      e.acc_cyc = cyc;
      last_rdata = e.rdata;
      sb_q.push_back(e);
    end
    @(negedge clk);
    core_req_valid = 1'b0;
    core_addr = $urandom;
    core_wdata = $urandom;
    if (ok) begin
      waited = 0;
      #1;
      while (!core_done && waited < 40) begin
        @(negedge clk);
        #1;
        waited++;
      end
      if (!core_done) chk("done_seen", 32'(core_done), 32'd1);
    end
  endtask

  task automatic reset_in_resp();
    bit ok;
    int waited = 0;
    cur_noack = 1'b0; cur_nvalid = 1'b1; cur_req_d = 0; cur_resp_d = 0;
    set_bus_expect(32'h0000_0400, 8'h01, 32'h0);
    core_addr = 32'h0000_0400; core_type = 8'h01; core_req_valid = 1'b1;
    wait_ack(ok);
    @(negedge clk);
    core_req_valid = 1'b0;
    #1;
    while (!Read_data_Ack && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("reached_resp", 32'(Read_data_Ack), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_resp_rdack", 32'(Read_data_Ack), 32'd0);
    chk("rst_resp_done", 32'(core_done), 32'd0);
    chk("rst_resp_rdata", core_rdata, 32'd0);
    last_rdata = '0;
    bus_seen = 0;
    cur_nvalid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t;
    int r;
    rst = 1'b1;
    core_req_valid = 1'b0;
    core_addr = '0; core_type = '0; core_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_Address", Address, 32'd0);
    chk("rst_Write_strb", 32'(Write_strb), 32'd0);
    chk("rst_mem_rw", 32'({MemRead, MemWrite}), 32'd0);
    chk("rst_done_err", 32'({core_done, core_err}), 32'd0);
    chk("rst_rdack", 32'(Read_data_Ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h0000_0100, 8'h01, 32'h0, 32'h89AB_CDEF, 0, 0, 0, 0);
    issue(32'h0000_0103, 8'h02, 32'h0, 32'h8011_2233, 1, 1, 0, 0);
    issue(32'h0000_0103, 8'h04, 32'h0, 32'h8011_2233, 0, 2, 0, 0);
    issue(32'h0000_0202, 8'h80, 32'h0000_BEEF, 32'h0, 0, 0, 0, 0);
    issue(32'h0000_0301, 8'h40, 32'h1234_56A5, 32'h0, 2, 0, 0, 0);
    issue(32'h0000_0300, 8'h01, 32'h0, 32'h0, 0, 0, 1, 0);
    issue(32'h0000_0300, 8'h20, 32'hCAFE_F00D, 32'h0, 0, 0, 1, 0);
    issue(32'h0000_0102, 8'h08, 32'h0, 32'h8765_4321, 1, 0, 0, 1);
    issue(32'h0000_0101, 8'h01, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0);
    issue(32'h0000_0040, 8'h00, 32'h0, 32'h0, 0, 0, 0, 0);
    issue(32'h0000_0040, 8'h03, 32'h0, 32'h0, 0, 0, 0, 0);
    issue(32'h0000_0106, 8'h10, 32'h0, 32'hF00D_8001, 0, 1, 0, 0);
    reset_in_resp();
    issue(32'h0000_0500, 8'h01, 32'h0, 32'h1357_9BDF, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 16) t = 8'(1 << (r % 8));
      else if (r == 16) t = 8'h00;
      else t = 8'($urandom) | 8'h11;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue($urandom, t, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
